if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 StallF  input  1  hold the current fetched instruction and PC.
REQ-005 PCSrcE  input  1  redirect request from execute.
REQ-006 PCTargetE  input  32  redirect target address.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_ready  input  1  memory accepts request.
REQ-009 imem_addr  output  32  fetch address (= PC register).
REQ-010 imem_rsp_valid  input  1  response data valid.
REQ-011 imem_rsp_data  input  32  fetched instruction word.
REQ-012 PCF, InstrF, PCPlus4F  output  32 each  fetched PC, instruction, PC+4 toward decode register.
REQ-013 ValidF  output  1  PCF/InstrF/PCPlus4F valid this cycle; decode register load enable.
REQ-014 PredTakenF  output  1  static prediction taken for InstrF.

Function
REQ-015 FSM states: REQ, WAIT, VALID, DROP; at most one outstanding memory request.
REQ-016 REQ: imem_req_valid=1, imem_addr=PC; on imem_req_ready go WAIT.
REQ-017 WAIT: on imem_rsp_valid capture data into instruction register, go VALID; latency from response to ValidF is exactly 1 cycle.
REQ-018 VALID: ValidF=1; if StallF=0, PC <= next PC, go REQ; if StallF=1, stay, all outputs stable.
REQ-019 Next PC SHALL be PCF+4, or branch target when PredTakenF=1 (REQ-030); adds wrap modulo 2^32.
REQ-020 PCPlus4F SHALL equal PCF+4 modulo 2^32.
REQ-021 PCSrcE=1 has priority over StallF and any state: PC <= PCTargetE, ValidF=0 in that cycle.
REQ-022 Redirect in REQ without handshake, or in VALID: go REQ; redirect in REQ with handshake same cycle: go DROP.
REQ-023 Redirect in WAIT: go DROP, or REQ if imem_rsp_valid same cycle (response discarded).
REQ-024 DROP: imem_req_valid=0; discard next response, go REQ; further redirects update PC, stay DROP.
REQ-025 imem_rsp_valid in REQ or VALID is a protocol error; ignored.
REQ-026 imem_req_valid SHALL not drop before handshake except on redirect.

Reset
REQ-027 While rst=0: PC=RESET_PC, state=REQ, imem_req_valid=0, ValidF=0, InstrF=0, PredTakenF=0.
REQ-028 First request issues in the first cycle after rst deasserts with imem_addr=RESET_PC.
REQ-029 Reset mid-transaction abandons any outstanding request; a late response after reset is not expected and not consumed.

Configuration
REQ-030 With IF_STAGE_BTFN_EN defined: InstrF opcode 7'b1100011 with imm sign bit (InstrF[31]) set SHALL set PredTakenF=1 and next PC = PCF + sign-extended B-immediate.
REQ-031 Without IF_STAGE_BTFN_EN: PredTakenF tied 0, next PC always PCF+4.

Structure
REQ-032 Shared package if_pkg SHALL hold the FSM state enum, OPCODE_BRANCH, and default RESET_PC constant.
REQ-033 One combinational sub-module, pc_next_gen, SHALL compute PC+4, B-immediate target and PredTakenF.

Verification
REQ-034 Reset release, imem ready always, 1-cycle response -> addresses 0x0,0x4,0x8 issued; ValidF pulses with PCF matching, PCPlus4F=PCF+4.
REQ-035 StallF=1 for 3 cycles in VALID with PCF=0x8 -> PCF, InstrF held, no new request issued, ValidF stays 1.
REQ-036 PCSrcE=1, PCTargetE=0x100 in WAIT -> DROP; stale response ignored; next request addr=0x100; ValidF never shows stale word.
REQ-037 PCSrcE and StallF both 1 in VALID -> redirect wins, next imem_addr=PCTargetE.
REQ-038 PCF=0xFFFF_FFFC -> PCPlus4F=0x0, next fetch addr 0x0.
REQ-039 BTFN on: InstrF=32'hFE000EE3 (beq, imm=-4) at PCF=0x20 -> PredTakenF=1, next addr 0x1C; BTFN off -> 0x24.

Source files
------------

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared fetch-stage types and constants
package if_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

  localparam logic [6:0]  OPCODE_BRANCH    = 7'b1100011;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory request/response bundle
interface if_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/if_stage_pc_next_gen.sv
// rtl/if_stage_pc_next_gen.sv - PC+4, B-immediate target and static prediction
// Backward-taken prediction only when IF_STAGE_BTFN_EN is defined.
module pc_next_gen
  import if_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] target_o,
  output logic        pred_taken_o
);

  logic [31:0] b_imm;

  assign b_imm      = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign pc_plus4_o = pc_i + 32'd4;
  assign target_o   = pc_i + b_imm;

`ifdef IF_STAGE_BTFN_EN
  // A branch with negative offset is a backward branch: predict taken.
  assign pred_taken_o = (instr_i[6:0] == OPCODE_BRANCH) && instr_i[31];
  logic unused_bits;
  assign unused_bits = ^instr_i[24:12];
`else
  assign pred_taken_o = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{instr_i[24:12], instr_i[6:0]};
`endif

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage, one outstanding imem request
// Optional static backward-branch prediction via IF_STAGE_BTFN_EN.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallF,
  input  logic               PCSrcE,
  input  logic [31:0]        PCTargetE,
  if_stage_if.master         imem,
  output logic [31:0]        PCF,
  output logic [31:0]        InstrF,
  output logic [31:0]        PCPlus4F,
  output logic               ValidF,
  output logic               PredTakenF
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_plus4, br_target, next_pc;
  logic         pred_taken;

  pc_next_gen u_pc_next_gen (
    .pc_i         (pc_q),
    .instr_i      (instr_q),
    .pc_plus4_o   (pc_plus4),
    .target_o     (br_target),
    .pred_taken_o (pred_taken)
  );

  assign next_pc = pred_taken ? br_target : pc_plus4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Redirects take priority everywhere; a response already in flight is
  // discarded either immediately (same cycle) or via DROP.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_REQ: begin
        if (PCSrcE) begin
          pc_d    = PCTargetE;
          state_d = imem.imem_req_ready ? ST_DROP : ST_REQ;
        end else if (imem.imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (PCSrcE) begin
          pc_d    = PCTargetE;
          state_d = imem.imem_rsp_valid ? ST_REQ : ST_DROP;
        end else if (imem.imem_rsp_valid) begin
          instr_d = imem.imem_rsp_data;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (PCSrcE) begin
          pc_d    = PCTargetE;
          state_d = ST_REQ;
        end else if (!StallF) begin
          pc_d    = next_pc;
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (PCSrcE) begin
          pc_d = PCTargetE;
        end
        if (imem.imem_rsp_valid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // Request is masked during reset even though the state sits in REQ.
  assign imem.imem_req_valid = rst && (state_q == ST_REQ);
  assign imem.imem_addr      = pc_q;

  assign PCF        = pc_q;
  assign InstrF     = instr_q;
  assign PCPlus4F   = pc_plus4;
  assign PredTakenF = pred_taken;
  assign ValidF     = (state_q == ST_VALID) && !PCSrcE;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage
module tb_if_stage;
  import if_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } vexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic [31:0] PCF, InstrF, PCPlus4F;
  logic        ValidF, PredTakenF;

  if_stage_if imem ();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem       (imem),
    .PCF        (PCF),
    .InstrF     (InstrF),
    .PCPlus4F   (PCPlus4F),
    .ValidF     (ValidF),
    .PredTakenF (PredTakenF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h20) return 32'hFE000EE3;
    return {a[23:0], 8'h13};
  endfunction

  // Memory: always ready, answers one cycle after the handshake unless held.
  logic        pend_q;
  logic [31:0] pend_addr_q;
  bit          hold_rsp = 1'b0;

  assign imem.imem_req_ready = 1'b1;
  assign imem.imem_rsp_valid = pend_q && !hold_rsp;
  assign imem.imem_rsp_data  = mem_word(pend_addr_q);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= 1'b0;
      pend_addr_q <= 32'h0;
    end else begin
      if (imem.imem_rsp_valid) pend_q <= 1'b0;
      if (imem.imem_req_valid && imem.imem_req_ready) begin
        pend_q      <= 1'b1;
        pend_addr_q <= imem.imem_addr;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  logic [31:0] req_q[$];
  vexp_t       val_q[$];
  bit          chk_en = 1'b1;
  bit          held = 1'b0;
  vexp_t       cur;

  always @(negedge clk) begin
    if (chk_en && imem.imem_req_valid && imem.imem_req_ready) begin
      if (req_q.size() == 0) fail_now("unexpected_req");
      else check("req_addr", imem.imem_addr, req_q.pop_front());
    end
  end

  // A stalled instruction is re-checked against the same entry each cycle.
  always @(negedge clk) begin
    if (chk_en && ValidF) begin
      if (!held) begin
        if (val_q.size() == 0) begin
          fail_now("unexpected_valid");
          cur = '0;
        end else begin
          cur = val_q.pop_front();
        end
      end
      check("valid_pc", PCF, cur.pc);
      check("valid_instr", InstrF, cur.instr);
      check("valid_pcplus4", PCPlus4F, cur.pc + 32'd4);
      check("valid_pred", {31'b0, PredTakenF}, {31'b0, cur.pred});
    end
    held = ValidF && StallF;
  end

  task automatic wait_req(input logic [31:0] a);
    for (int i = 0; i < 60; i++) begin
      if (imem.imem_req_valid && imem.imem_addr == a) return;
      @(posedge clk); #1;
    end
    fail_now("wait_req_timeout");
  endtask

  task automatic wait_valid(input logic [31:0] a);
    for (int i = 0; i < 60; i++) begin
      if (ValidF && PCF == a) return;
      @(posedge clk); #1;
    end
    fail_now("wait_valid_timeout");
  endtask

  logic        exp_pred20;
  logic [31:0] exp_next20;

  initial begin
`ifdef IF_STAGE_BTFN_EN
    exp_pred20 = 1'b1;
    exp_next20 = 32'h1C;
`else
    exp_pred20 = 1'b0;
    exp_next20 = 32'h24;
`endif
    req_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h200, 32'h204,
              32'hFFFF_FFFC, 32'h0, 32'h20, exp_next20};
    val_q.push_back('{32'h0,         32'h0000_0013, 1'b0});
    val_q.push_back('{32'h4,         32'h0000_0413, 1'b0});
    val_q.push_back('{32'h8,         32'h0000_0813, 1'b0});
    val_q.push_back('{32'h100,       32'h0001_0013, 1'b0});
    val_q.push_back('{32'h200,       32'h0002_0013, 1'b0});
    val_q.push_back('{32'hFFFF_FFFC, 32'hFFFF_FC13, 1'b0});
    val_q.push_back('{32'h20,        32'hFE00_0EE3, exp_pred20});

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", {31'b0, imem.imem_req_valid}, 32'h0);
    check("rst_validf", {31'b0, ValidF}, 32'h0);
    check("rst_instrf", InstrF, 32'h0);
    check("rst_pred", {31'b0, PredTakenF}, 32'h0);
    check("rst_pc", PCF, 32'h0);

    rst = 1'b1;
    #1;
    check("first_req_valid", {31'b0, imem.imem_req_valid}, 32'h1);
    check("first_req_addr", imem.imem_addr, 32'h0);

    wait_valid(32'h8);
    StallF = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("stall_validf", {31'b0, ValidF}, 32'h1);
      check("stall_no_req", {31'b0, imem.imem_req_valid}, 32'h0);
      check("stall_pcf", PCF, 32'h8);
      check("stall_instrf", InstrF, 32'h0000_0813);
    end
    StallF   = 1'b0;
    hold_rsp = 1'b1;

    wait_req(32'hC);
    @(posedge clk); #1;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h100;
    #1;
    check("wait_redirect_validf", {31'b0, ValidF}, 32'h0);
    @(posedge clk); #1;
    PCSrcE = 1'b0;
    check("drop_req_low", {31'b0, imem.imem_req_valid}, 32'h0);
    hold_rsp = 1'b0;
    @(posedge clk); #1;
    check("after_drop_addr", imem.imem_addr, 32'h100);
    check("after_drop_req", {31'b0, imem.imem_req_valid}, 32'h1);

    wait_valid(32'h100);
    StallF = 1'b1;
    @(posedge clk); #1;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h200;
    #1;
    check("redirect_kills_validf", {31'b0, ValidF}, 32'h0);
    @(posedge clk); #1;
    PCSrcE = 1'b0;
    StallF = 1'b0;
    check("redirect_wins_addr", imem.imem_addr, 32'h200);

    wait_req(32'h204);
    PCSrcE    = 1'b1;
    PCTargetE = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    PCSrcE = 1'b0;
    check("req_hs_redirect_drop", {31'b0, imem.imem_req_valid}, 32'h0);

    wait_valid(32'hFFFF_FFFC);
    check("wrap_pcplus4", PCPlus4F, 32'h0);

    wait_req(32'h0);
    PCSrcE    = 1'b1;
    PCTargetE = 32'h20;
    @(posedge clk); #1;
    PCSrcE = 1'b0;

    wait_valid(32'h20);
    check("btfn_pred", {31'b0, PredTakenF}, {31'b0, exp_pred20});
    wait_req(exp_next20);
    @(posedge clk); #1;
    chk_en = 1'b0;
    check("req_queue_left", req_q.size(), 32'h0);
    check("valid_queue_left", val_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
